// File: rtl/adder_share_arb.sv
// adder_share_arb
//
// Shares one WIDTH-bit parallel-prefix adder between NREQ requesters. A
// combinational round-robin arbiter grants one requester per cycle. The block
// registers the granted requester's sum, carry-out and index into a single
// output stage that supports backpressure.
//
// Optional feature (compile-time macro ADDER_SHARE_ARB_CHAIN_EN):
//   Chain mode. A beat with req_last=0 locks the arbiter onto its requester.
//   The registered carry-out of that beat becomes the carry-in of the next
//   beat, so multi-word adds run back to back. The lock is released by a beat
//   with req_last=1. Without the macro, req_last is ignored and the arbiter
//   never locks.
//
// Parameters:
//   WIDTH       operand / sum width
//   NREQ        number of requesters (2..8)
//   IDW         requester index width
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester operand valid
//   req_ready_o  per-requester accept, one-hot or zero
//   req_a_i      operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b_i      operand B, same packing
//   req_cin_i    per-requester carry-in
//   req_last_i   last beat of a chained add (chain mode only)
//   out_valid_o  result register holds a valid result
//   out_ready_i  downstream accepts the result
//   out_sum_o    registered (a+b+cin) mod 2^WIDTH
//   out_cout_o   registered carry-out
//   out_id_o     index of the requester that produced the result
module adder_share_arb #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    input  logic [NREQ-1:0]       req_cin_i,
    input  logic [NREQ-1:0]       req_last_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WIDTH-1:0]      out_sum_o,
    output logic                  out_cout_o,
    output logic [IDW-1:0]        out_id_o
);

    localparam int unsigned Levels = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
`ifdef ADDER_SHARE_ARB_CHAIN_EN
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFull     = 2'd1,
        StLockIdle = 2'd2,
        StLockFull = 2'd3
    } state_e;
`else
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StFull = 1'b1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [IDW-1:0]   id_q, id_d;

`ifdef ADDER_SHARE_ARB_CHAIN_EN
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic             chain_c_q, chain_c_d;
    logic             locked;
`endif

    logic             out_valid;
    logic             stage_free;
    logic             xfer;
    logic             drain;

    logic             rr_found;
    logic [IDW-1:0]   rr_idx;
    logic [IDW-1:0]   rr_cand;
    int unsigned      scan_idx;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr_inc;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;
    logic             open_chain;
    logic             advance_ptr;

    logic [WIDTH-1:0] pg_g, pg_p, pg_g_n, pg_p_n;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

`ifdef ADDER_SHARE_ARB_CHAIN_EN
    assign out_valid = (state_q == StFull) || (state_q == StLockFull);
    assign locked    = (state_q == StLockIdle) || (state_q == StLockFull);
`else
    assign out_valid = (state_q == StFull);
`endif

    assign stage_free = !out_valid || out_ready_i;

    // ------------------------------------------------------------------
    // Round-robin scan starting at ptr_q
    // ------------------------------------------------------------------
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = 32'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            rr_cand = IDW'(scan_idx);
            if (!rr_found && req_valid_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

`ifdef ADDER_SHARE_ARB_CHAIN_EN
    // While locked only the chain owner may be granted; others wait.
    assign grant_found = locked ? req_valid_i[lock_id_q] : rr_found;
    assign grant_idx   = locked ? lock_id_q : rr_idx;
    // Chained beats take their carry from the previous beat, not req_cin.
    assign sel_cin     = locked ? chain_c_q : req_cin_i[grant_idx];
    assign open_chain  = !locked && !req_last_i[grant_idx];
    assign advance_ptr = !locked || req_last_i[grant_idx];
`else
    logic unused_last;
    assign unused_last = ^req_last_i;
    assign grant_found = rr_found;
    assign grant_idx   = rr_idx;
    assign sel_cin     = req_cin_i[grant_idx];
    assign open_chain  = 1'b0;
    assign advance_ptr = 1'b1;
`endif

    assign xfer  = grant_found && stage_free && !rst_i;
    assign drain = out_valid && out_ready_i && !xfer;

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign ptr_inc = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // ------------------------------------------------------------------
    // Shared adder: operand mux feeding a Kogge-Stone prefix carry tree
    // ------------------------------------------------------------------
    assign sel_a = req_a_i[grant_idx*WIDTH +: WIDTH];
    assign sel_b = req_b_i[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        pg_g   = sel_a & sel_b;
        pg_p   = sel_a ^ sel_b;
        pg_g_n = pg_g;
        pg_p_n = pg_p;
        for (int unsigned lv = 0; lv < Levels; lv++) begin
            pg_g_n = pg_g;
            pg_p_n = pg_p;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i >= (32'd1 << lv)) begin
                    pg_g_n[i] = pg_g[i] | (pg_p[i] & pg_g[i - (32'd1 << lv)]);
                    pg_p_n[i] = pg_p[i] & pg_p[i - (32'd1 << lv)];
                end
            end
            pg_g = pg_g_n;
            pg_p = pg_p_n;
        end
        // pg_g/pg_p now hold group generate/propagate over bits [i:0].
        carry[0] = sel_cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry[i+1] = pg_g[i] | (pg_p[i] & sel_cin);
        end
    end

    assign add_sum  = (sel_a ^ sel_b) ^ carry[WIDTH-1:0];
    assign add_cout = carry[WIDTH];

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        id_d    = id_q;
`ifdef ADDER_SHARE_ARB_CHAIN_EN
        lock_id_d = lock_id_q;
        chain_c_d = chain_c_q;
`endif

        unique case (state_q)
            StIdle, StFull: begin
                if (xfer) begin
                    state_d = open_chain ? state_e'(2'd3) : StFull;
                end else if (drain) begin
                    state_d = StIdle;
                end
            end
`ifdef ADDER_SHARE_ARB_CHAIN_EN
            StLockIdle, StLockFull: begin
                if (xfer) begin
                    state_d = req_last_i[grant_idx] ? StFull : StLockFull;
                end else if (drain) begin
                    state_d = StLockIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (xfer) begin
            sum_d  = add_sum;
            cout_d = add_cout;
            id_d   = grant_idx;
            if (advance_ptr) begin
                ptr_d = ptr_inc;
            end
`ifdef ADDER_SHARE_ARB_CHAIN_EN
            if (!req_last_i[grant_idx]) begin
                lock_id_d = grant_idx;
                chain_c_d = add_cout;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
`ifdef ADDER_SHARE_ARB_CHAIN_EN
            lock_id_q <= '0;
            chain_c_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
`ifdef ADDER_SHARE_ARB_CHAIN_EN
            lock_id_q <= lock_id_d;
            chain_c_q <= chain_c_d;
`endif
        end
    end

    assign out_valid_o = out_valid;
    assign out_sum_o   = sum_q;
    assign out_cout_o  = cout_q;
    assign out_id_o    = id_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb (WIDTH=12, NREQ=4).
// Expected results go into a scoreboard queue on each expected grant and are
// compared while the DUT presents them on out_*.
module tb_adder_share_arb;

    localparam int W  = 12;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0;
    logic [N*W-1:0]  req_b = '0;
    logic [N-1:0]    req_cin = '0;
    logic [N-1:0]    req_last = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_sum;
    logic            out_cout;
    logic [IW-1:0]   out_id;

    always #5 clk = ~clk;

    adder_share_arb #(.WIDTH(W), .NREQ(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_cin_i   (req_cin),
        .req_last_i  (req_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_cout_o  (out_cout),
        .out_id_o    (out_id)
    );

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N-1:0]   cin;
        logic [N-1:0]   last;
        logic           oready;
        logic [N-1:0]   exp_ready;
        logic [W-1:0]   exp_sum;
        logic           exp_cout;
        logic [IW-1:0]  exp_id;
    } vec_t;

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          cout;
        logic [IW-1:0] id;
    } res_t;

    res_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mdl_valid = 1'b0;
    vec_t tbl[7];

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] a3, input logic [W-1:0] a2,
                                          input logic [W-1:0] a1, input logic [W-1:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic [N-1:0] valid, input logic [N*W-1:0] a,
                                input logic [N*W-1:0] b, input logic [N-1:0] cin,
                                input logic [N-1:0] last, input logic oready,
                                input logic [N-1:0] exp_ready, input logic [W-1:0] exp_sum,
                                input logic exp_cout, input logic [IW-1:0] exp_id);
        vec_t v;
        v.valid = valid; v.a = a; v.b = b; v.cin = cin; v.last = last; v.oready = oready;
        v.exp_ready = exp_ready; v.exp_sum = exp_sum; v.exp_cout = exp_cout; v.exp_id = exp_id;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs and grant, update the model.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        req_cin   = v.cin;
        req_last  = v.last;
        out_ready = v.oready;
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(mdl_valid));
        if (mdl_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s scoreboard: got result with none expected", tag);
            end else begin
                check({tag, " out_sum"}, 32'(out_sum), 32'(sb_q[0].sum));
                check({tag, " out_cout"}, 32'(out_cout), 32'(sb_q[0].cout));
                check({tag, " out_id"}, 32'(out_id), 32'(sb_q[0].id));
                if (v.oready) void'(sb_q.pop_front());
            end
        end
        check({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
        if (v.exp_ready != '0) begin
            sb_q.push_back('{v.exp_sum, v.exp_cout, v.exp_id});
        end
        mdl_valid = (v.exp_ready != '0) || (mdl_valid && !v.oready);
    endtask

    // Random operands; expected sum from plain integer addition for grant gid.
    task automatic beat_rand(input logic [N-1:0] valid, input logic oready, input int gid,
                             input string tag);
        logic [W-1:0] aa[N];
        logic [W-1:0] bb[N];
        logic [N-1:0] cc;
        logic [W:0]   s;
        vec_t         v;
        for (int i = 0; i < N; i++) begin
            aa[i] = W'($urandom);
            bb[i] = W'($urandom);
        end
        cc = N'($urandom);
        s = 13'(aa[0]);
        if (gid >= 0) s = {1'b0, aa[gid]} + {1'b0, bb[gid]} + 13'(cc[gid]);
        v = mk(valid, pk(aa[3], aa[2], aa[1], aa[0]), pk(bb[3], bb[2], bb[1], bb[0]), cc, '1,
               oready, (gid >= 0) ? N'(1 << gid) : '0, s[W-1:0], s[W], IW'(gid));
        apply(v, tag);
    endtask

    task automatic idle(input string tag);
        apply(mk('0, '0, '0, '0, '0, 1'b1, '0, '0, 1'b0, '0), tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        out_ready = 1'b0;
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        #1;
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        check("post-rst out_sum", 32'(out_sum), 32'd0);
        check("post-rst out_cout", 32'(out_cout), 32'd0);
        check("post-rst out_id", 32'(out_id), 32'd0);
        check("post-rst req_ready", 32'(req_ready), 32'd0);
        sb_q.delete();
        mdl_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table; the pointer starts at 0 after reset.
        tbl[0] = mk(4'b0001, pk(12'h0, 12'h0, 12'h0, 12'hFFF), pk(12'h0, 12'h0, 12'h0, 12'h001),
                    4'b0000, '0, 1'b1, 4'b0001, 12'h000, 1'b1, 2'd0);
        tbl[1] = mk(4'b0000, '0, '0, '0, '0, 1'b1, 4'b0000, 12'h0, 1'b0, 2'd0);
        tbl[2] = mk(4'b0101, pk(12'h111, 12'h123, 12'h222, 12'h333),
                    pk(12'h444, 12'h456, 12'h555, 12'h666), 4'b0100, '0, 1'b1,
                    4'b0100, 12'h57A, 1'b0, 2'd2);
        tbl[3] = mk(4'b0011, pk(12'h0AA, 12'h0BB, 12'h0CC, 12'h800),
                    pk(12'h011, 12'h022, 12'h033, 12'h800), 4'b0001, '0, 1'b1,
                    4'b0001, 12'h001, 1'b1, 2'd0);
        tbl[4] = mk(4'b1000, pk(12'h0AB, 12'h777, 12'h777, 12'h777),
                    pk(12'hF00, 12'h777, 12'h777, 12'h777), 4'b0111, '0, 1'b1,
                    4'b1000, 12'hFAB, 1'b0, 2'd3);
        tbl[5] = mk(4'b0110, pk(12'h001, 12'h002, 12'hFFF, 12'h003),
                    pk(12'h004, 12'h005, 12'hFFF, 12'h006), 4'b0010, '0, 1'b1,
                    4'b0010, 12'hFFF, 1'b1, 2'd1);
        tbl[6] = mk(4'b0000, '0, '0, '0, '0, 1'b1, 4'b0000, 12'h0, 1'b0, 2'd0);

        repeat (2) @(posedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) idle("idle");
        check("idle out_sum", 32'(out_sum), 32'd0);

        for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Fairness from a fresh pointer: ids 0,1,2,3,0,1,2,3.
        do_reset();
        for (int k = 0; k < 8; k++) beat_rand(4'b1111, 1'b1, k % N, $sformatf("fair%0d", k));

        // Backpressure: grant 0, stall 3 cycles, release grants 1.
        beat_rand(4'b1111, 1'b1, 0, "bp grant");
        for (int k = 0; k < 3; k++) beat_rand(4'b1111, 1'b0, -1, $sformatf("bp stall%0d", k));
        beat_rand(4'b1111, 1'b1, 1, "bp release");
        idle("bp drain");
        idle("bp idle");

        // Reset while a result is held discards it.
        beat_rand(4'b0100, 1'b0, 2, "hold");
        beat_rand(4'b0000, 1'b0, -1, "hold2");
        do_reset();
        idle("after rst");

`ifdef ADDER_SHARE_ARB_CHAIN_EN
        // Move the pointer to 2, then chain on requester 2 with 1 waiting.
        apply(mk(4'b0010, pk(12'h0, 12'h0, 12'h010, 12'h0), pk(12'h0, 12'h0, 12'h020, 12'h0),
                 4'b0000, 4'b0010, 1'b1, 4'b0010, 12'h030, 1'b0, 2'd1), "ch pre");
        apply(mk(4'b0110, pk(12'h0, 12'hFFF, 12'h100, 12'h0), pk(12'h0, 12'h001, 12'h200, 12'h0),
                 4'b0000, 4'b0010, 1'b1, 4'b0100, 12'h000, 1'b1, 2'd2), "ch beat1");
        apply(mk(4'b0010, pk(12'h0, 12'h0, 12'h100, 12'h0), pk(12'h0, 12'h0, 12'h200, 12'h0),
                 4'b0000, 4'b0010, 1'b1, 4'b0000, 12'h0, 1'b0, 2'd0), "ch wait");
        apply(mk(4'b0110, pk(12'h0, 12'h000, 12'h100, 12'h0), pk(12'h0, 12'h000, 12'h200, 12'h0),
                 4'b0000, 4'b0110, 1'b1, 4'b0100, 12'h001, 1'b0, 2'd2), "ch beat2");
        apply(mk(4'b0010, pk(12'h0, 12'h0, 12'h100, 12'h0), pk(12'h0, 12'h0, 12'h200, 12'h0),
                 4'b0000, 4'b0010, 1'b1, 4'b0010, 12'h300, 1'b0, 2'd1), "ch after");
        idle("ch drain");

        // Reset mid-chain: pointer returns to 0, lowest valid index wins.
        apply(mk(4'b0100, pk(12'h0, 12'hFFF, 12'h0, 12'h0), pk(12'h0, 12'h001, 12'h0, 12'h0),
                 4'b0000, 4'b0000, 1'b1, 4'b0100, 12'h000, 1'b1, 2'd2), "chr beat1");
        do_reset();
        apply(mk(4'b0110, pk(12'h0, 12'h0, 12'h005, 12'h0), pk(12'h0, 12'h0, 12'h006, 12'h0),
                 4'b0000, 4'b0110, 1'b1, 4'b0010, 12'h00B, 1'b0, 2'd1), "chr next");
        idle("chr drain");
`endif

        idle("final");
        check("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
